cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter.sv | 76 +++++++
 tb/tb_cache_mem_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one memory beat port between Icache refills and
// Dcache refill/writeback bursts, alternating ownership on simultaneous requests.
module cache_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BURST_LEN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ic_req,
  input  logic [AW-1:0] ic_addr,
  output logic          ic_rvalid,
  output logic          ic_done,
  input  logic          dc_req,
  input  logic          dc_we,
  input  logic [AW-1:0] dc_addr,
  input  logic [DW-1:0] dc_wdata,
  output logic          dc_wnext,
  output logic          dc_rvalid,
  output logic          dc_done,
  output logic [DW-1:0] rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);
  localparam int CW = $clog2(BURST_LEN);
  localparam int LB = CW + 2;
  localparam logic [AW-1:0] MASK = {{(AW-LB){1'b1}}, {LB{1'b0}}};
  typedef enum logic [1:0] {IDLE, BUSY_IC, BUSY_DC} state_t;
  state_t state;
  logic [AW-1:0] base;
  logic we;
  logic [CW-1:0] cnt;
  logic last_dc;
  logic busy, last, ic_win, rd;
  assign busy   = state != IDLE;
  assign last   = busy && mem_ack && cnt == CW'(BURST_LEN - 1);
  // Icache wins a tie only when the Dcache was served last
  assign ic_win = ic_req && (!dc_req || last_dc);
  assign rd     = busy && mem_ack && !we;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      base    <= '0;
      we      <= 1'b0;
      cnt     <= '0;
      last_dc <= 1'b1;
    end else if (state == IDLE) begin
      if (ic_req || dc_req) begin
        state <= ic_win ? BUSY_IC : BUSY_DC;
        base  <= (ic_win ? ic_addr : dc_addr) & MASK;
        we    <= !ic_win && dc_we;
        cnt   <= '0;
      end
    end else if (mem_ack) begin
      cnt <= cnt + CW'(1);
      if (last) begin
        state   <= IDLE;
        last_dc <= state == BUSY_DC;
      end
    end
  end
  assign mem_req   = busy;
  assign mem_we    = busy && we;
  assign mem_addr  = busy ? base + AW'({cnt, 2'b00}) : '0;
  assign mem_wdata = busy ? dc_wdata : '0;
  assign rdata     = busy ? mem_rdata : '0;
  assign ic_rvalid = rd && state == BUSY_IC;
  assign dc_rvalid = rd && state == BUSY_DC;
  assign dc_wnext  = state == BUSY_DC && we && mem_ack;
  assign ic_done   = last && state == BUSY_IC;
  assign dc_done   = last && state == BUSY_DC;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed bursts against a simple always-ready or
// every-other-cycle memory, with hand-derived addresses and handshakes.
module tb_cache_mem_arbiter;
  localparam int BL = 4;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic clk = 0, rst = 1;
  logic ic_req = 0, dc_req = 0, dc_we = 0, mem_ack = 0;
  logic [31:0] ic_addr = 0, dc_addr = 0, dc_wdata = 0;
  logic ic_rvalid, ic_done, dc_wnext, dc_rvalid, dc_done, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign mem_rdata = mem_addr ^ K;
  cache_mem_arbiter #(.AW(32), .DW(32), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wnext(dc_wnext), .dc_rvalid(dc_rvalid), .dc_done(dc_done), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic idle_outs(input string tag);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_outs"}, {ic_rvalid, ic_done, dc_rvalid, dc_wnext, dc_done, mem_we}, 0);
  endtask
  // called at a negedge while idle with requests already driven
  task automatic burst(input bit is_ic, input logic [31:0] base, input bit we,
                       input bit gap, input bit drop1, input bit keep);
    int beat = 0;
    int c = 0;
    bit ack;
    bit fin = 0;
    logic [31:0] a;
    chk("pre_idle", mem_req, 0);
    while (!fin && c < 40) begin
      @(negedge clk);
      ack = gap ? c[0] : 1'b1;
      mem_ack = ack;
      dc_wdata = 32'hD0 + beat;
      a = base + beat * 4;
      #1;
      chk("req", mem_req, 1);
      chk("addr", mem_addr, a);
      chk("we", mem_we, we);
      if (we) chk("wdata", mem_wdata, 32'hD0 + beat);
      chk("ic_rvalid", ic_rvalid, is_ic && ack && !we);
      chk("dc_rvalid", dc_rvalid, !is_ic && ack && !we);
      chk("dc_wnext", dc_wnext, !is_ic && ack && we);
      chk("ic_done", ic_done, is_ic && ack && beat == BL - 1);
      chk("dc_done", dc_done, !is_ic && ack && beat == BL - 1);
      if (ack && !we) chk("rdata", rdata, a ^ K);
      if (ack) beat++;
      c++;
      fin = beat == BL;
      if (drop1 && beat == 1) ic_req = 0;
      if (fin && !keep) begin
        if (is_ic) ic_req = 0;
        else dc_req = 0;
      end
    end
    chk("burst_fin", fin, 1);
    @(negedge clk);
    mem_ack = 0;
    #1;
    idle_outs("post");
  endtask
  initial begin
    #1;
    idle_outs("rst");
    chk("rst_addr", mem_addr, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    mem_ack = 1;
    repeat (3) begin
      @(negedge clk);
      #1;
      idle_outs("idle_ack");
    end
    mem_ack = 0;
    // tie right after reset: IC first, then a repeated tie goes to DC
    ic_addr = 32'h1004;
    dc_addr = 32'h3008;
    dc_we = 0;
    ic_req = 1;
    dc_req = 1;
    burst(1, 32'h1000, 0, 0, 0, 1);
    burst(0, 32'h3000, 0, 0, 0, 0);
    burst(1, 32'h1000, 0, 0, 0, 0);
    // single IC refill
    ic_addr = 32'h104;
    ic_req = 1;
    burst(1, 32'h100, 0, 0, 0, 0);
    // DC writeback with wait states
    dc_addr = 32'h2000;
    dc_we = 1;
    dc_req = 1;
    burst(0, 32'h2000, 1, 1, 0, 0);
    // IC drops request mid-burst
    ic_addr = 32'h208;
    ic_req = 1;
    burst(1, 32'h200, 0, 0, 1, 0);
    // reset during beat 2 of a DC writeback
    dc_addr = 32'h2048;
    dc_we = 1;
    dc_req = 1;
    mem_ack = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_beat2_addr", mem_addr, 32'h2048);
    rst = 1;
    #1;
    chk("rst_async_req", mem_req, 0);
    chk("rst_no_done", dc_done, 0);
    chk("rst_no_wnext", dc_wnext, 0);
    @(negedge clk);
    rst = 0;
    mem_ack = 0;
    burst(0, 32'h2040, 1, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
